// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and default width for the shift-add multiplier
package mul_pkg;
    localparam int N_DEFAULT = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: 4-bit ripple-carry adder used as the multiplier add stage
module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign carry = c[4];
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned N x N multiplier, one partial product per clock
// The adder carry shifts into the top of the accumulator so no product bit is lost.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N + 1);

    if (N != 4) begin : g_bad_n
        $error("shift_add_multiplier: N must be 4 to match the 4-bit adder");
    end

    state_t        state, next_state;
    logic [N-1:0]  mcand, acc_hi, acc_lo, addend, sum;
    logic [CW-1:0] cnt;
    logic          carry, last;

    assign addend = acc_lo[0] ? mcand : '0;
    assign last   = cnt == CW'(N - 1);

    ripple_carry_adder u_add (
        .a     (acc_hi),
        .b     (addend),
        .cin   (1'b0),
        .sum   (sum),
        .carry (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state == IDLE ? (start ? CALC : IDLE) :
                     state == CALC ? (last ? DONE : CALC) : IDLE;
        busy       = state == CALC;
        done       = state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (state == IDLE && start) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
        end else if (state == CALC) begin
            acc_hi <= {carry, sum[N-1:1]};
            acc_lo <= {sum[0], acc_lo[N-1:1]};
            cnt    <= cnt + CW'(1);
            if (last) product <= {carry, sum, acc_lo[N-1:1]};
        end
    end
endmodule
